// File: rtl/dotprod_mem_pkg.sv
// Shared definitions for the dot-product SRAM responder: default geometry,
// per-bank FSM encodings and the bus slice-offset helper.
package dotprod_mem_pkg;

    localparam int DEF_ADDR_WIDTH    = 4;
    localparam int DEF_DATA_WIDTH    = 8;
    localparam int DEF_NUMS_SRAM_IN  = 2;
    localparam int DEF_NUMS_SRAM_OUT = 1;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    // Low bit of field idx in a bus of equal-width fields packed from bit 0 up.
    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/sram_bank_slice.sv
// One SRAM bank: storage array, IDLE/CLEAR sweep FSM, registered read port
// and a sticky access-error flag.
module sram_bank_slice
    import dotprod_mem_pkg::*;
#(
    parameter int Addr_Width = DEF_ADDR_WIDTH,
    parameter int Ram_Depth  = 1 << Addr_Width,
    parameter int Data_Width = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mem_clear,
    input  logic                  chip_select,
    input  logic                  write_en,
    input  logic                  read_en,
    input  logic [Addr_Width-1:0] addr_read,
    input  logic [Addr_Width-1:0] addr_write,
    input  logic [Data_Width-1:0] data_in,
    output logic [Data_Width-1:0] data_out,
    output logic                  read_valid,
    output logic                  clear_busy,
    output logic                  access_error
);

    logic [0:0]            state;
    logic [Addr_Width-1:0] clr_cnt;
    logic [Data_Width-1:0] mem [Ram_Depth];

    logic rd_req, wr_req, in_clear;
    logic rd_oor, wr_oor, rd_ok, wr_ok, err_set, clr_last;

    logic [Data_Width-1:0] rd_data_p1;
    logic                  vld_p1;
    logic                  err_q;

    assign in_clear = (state == ST_CLEAR);
    assign rd_req   = chip_select & read_en;
    assign wr_req   = chip_select & write_en;
    // Only reachable when Ram_Depth is configured below 2**Addr_Width.
    assign rd_oor   = (int'(addr_read)  >= Ram_Depth);
    assign wr_oor   = (int'(addr_write) >= Ram_Depth);
    assign rd_ok    = ~in_clear & rd_req & ~rd_oor;
    assign wr_ok    = ~in_clear & wr_req & ~wr_oor;
    assign err_set  = (in_clear & (rd_req | wr_req)) |
                      (~in_clear & ((rd_req & rd_oor) | (wr_req & wr_oor)));
    assign clr_last = (int'(clr_cnt) == Ram_Depth - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            clr_cnt <= '0;
        end else if (state == ST_IDLE) begin
            if (mem_clear) state <= ST_CLEAR;
        end else begin
            if (clr_last) begin
                state   <= ST_IDLE;
                clr_cnt <= '0;
            end else begin
                clr_cnt <= clr_cnt + 1'b1;
            end
        end
    end

    // Array is never reset; the sweep owns the write port while clearing.
    always_ff @(posedge clk) begin
        if (in_clear) begin
            mem[clr_cnt] <= '0;
        end else if (wr_ok) begin
            mem[addr_write] <= data_in;
        end
    end

    // Stage p1: registered read data (read-first against a same-cycle write).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_p1 <= '0;
            vld_p1     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            vld_p1 <= rd_ok;
            if (rd_ok)   rd_data_p1 <= mem[addr_read];
            if (err_set) err_q      <= 1'b1;
        end
    end

    assign data_out     = rd_data_p1;
    assign read_valid   = vld_p1;
    assign clear_busy   = in_clear;
    assign access_error = err_q;

endmodule

// File: rtl/sram_bank_responder.sv
// Memory-side responder for the dot-product SRAM control interface:
// one independent sram_bank_slice per operand/result bank on packed buses.
module sram_bank_responder
    import dotprod_mem_pkg::*;
#(
    parameter int Addr_Width    = DEF_ADDR_WIDTH,
    parameter int Ram_Depth     = 1 << Addr_Width,
    parameter int Nums_SRAM_In  = DEF_NUMS_SRAM_IN,
    parameter int Nums_SRAM_Out = DEF_NUMS_SRAM_OUT,
    parameter int Nums_SRAM     = Nums_SRAM_In + Nums_SRAM_Out,
    parameter int Data_Width    = DEF_DATA_WIDTH
) (
    input  logic                            clk,
    input  logic                            Mem_reset_n,
    input  logic [Nums_SRAM-1:0]            Mem_Clear,
    input  logic [Nums_SRAM-1:0]            En_Chip_Select,
    input  logic [Nums_SRAM-1:0]            En_Write,
    input  logic [Nums_SRAM-1:0]            En_Read,
    input  logic [Nums_SRAM*Addr_Width-1:0] Addr_Read,
    input  logic [Nums_SRAM*Addr_Width-1:0] Addr_Write,
    input  logic [Nums_SRAM*Data_Width-1:0] Data_In,
    output logic [Nums_SRAM*Data_Width-1:0] Data_Out,
    output logic [Nums_SRAM-1:0]            Read_Valid,
    output logic [Nums_SRAM-1:0]            Clear_Busy,
    output logic [Nums_SRAM-1:0]            Access_Error
);

    for (genvar i = 0; i < Nums_SRAM; i++) begin : g_bank
        sram_bank_slice #(
            .Addr_Width (Addr_Width),
            .Ram_Depth  (Ram_Depth),
            .Data_Width (Data_Width)
        ) u_bank (
            .clk          (clk),
            .rst_n        (Mem_reset_n),
            .mem_clear    (Mem_Clear[i]),
            .chip_select  (En_Chip_Select[i]),
            .write_en     (En_Write[i]),
            .read_en      (En_Read[i]),
            .addr_read    (Addr_Read[slice_lo(i, Addr_Width) +: Addr_Width]),
            .addr_write   (Addr_Write[slice_lo(i, Addr_Width) +: Addr_Width]),
            .data_in      (Data_In[slice_lo(i, Data_Width) +: Data_Width]),
            .data_out     (Data_Out[slice_lo(i, Data_Width) +: Data_Width]),
            .read_valid   (Read_Valid[i]),
            .clear_busy   (Clear_Busy[i]),
            .access_error (Access_Error[i])
        );
    end

endmodule

// File: tb/tb_sram_bank_responder.sv
// Bench for sram_bank_responder: directed table, multi-cycle corner sequences
// and randomized traffic against a behavioural bank model.
module tb_sram_bank_responder;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int NB = 3;
    localparam int RD = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NB-1:0]     mem_clear, cs, we, re;
    logic [NB*AW-1:0]  ra, wa;
    logic [NB*DW-1:0]  din;
    logic [NB*DW-1:0]  dout;
    logic [NB-1:0]     rvld, busy, err;

    int vectors = 0;
    int miscompares = 0;

    sram_bank_responder dut (
        .clk            (clk),
        .Mem_reset_n    (rst_n),
        .Mem_Clear      (mem_clear),
        .En_Chip_Select (cs),
        .En_Write       (we),
        .En_Read        (re),
        .Addr_Read      (ra),
        .Addr_Write     (wa),
        .Data_In        (din),
        .Data_Out       (dout),
        .Read_Valid     (rvld),
        .Clear_Busy     (busy),
        .Access_Error   (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NB-1:0]    cs, we, re;
        logic [NB*AW-1:0] wa, ra;
        logic [NB*DW-1:0] din;
        logic [NB-1:0]    exp_rvld;
        logic [NB*DW-1:0] exp_dout;
    } vec_t;

    vec_t tbl[8];

    // Behavioural model state
    int         m_busy_left[NB];
    logic [7:0] m_mem[NB][RD];
    bit         m_known[NB][RD];
    logic [7:0] m_dout[NB];
    bit         m_dknown[NB];
    bit         m_err[NB];
    bit         m_rvld[NB];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        mem_clear = '0; cs = '0; we = '0; re = '0;
        ra = '0; wa = '0; din = '0;
    endtask

    task automatic set_bank(input int b, input bit s, input bit w, input bit r,
                            input logic [3:0] wad, input logic [3:0] rad, input logic [7:0] d);
        cs[b] = s; we[b] = w; re[b] = r;
        wa[b*AW +: AW] = wad;
        ra[b*AW +: AW] = rad;
        din[b*DW +: DW] = d;
    endtask

    function automatic logic [7:0] dout_b(input int b);
        return dout[b*DW +: DW];
    endfunction

    task automatic model_cycle();
        for (int b = 0; b < NB; b++) begin
            bit r, w;
            int rad, wad;
            r = cs[b] & re[b];
            w = cs[b] & we[b];
            rad = int'(ra[b*AW +: AW]);
            wad = int'(wa[b*AW +: AW]);
            if (m_busy_left[b] > 0) begin
                if (r || w) m_err[b] = 1'b1;
                m_rvld[b] = 1'b0;
                m_mem[b][RD - m_busy_left[b]]   = 8'h00;
                m_known[b][RD - m_busy_left[b]] = 1'b1;
                m_busy_left[b]--;
            end else begin
                m_rvld[b] = r;
                if (r) begin
                    m_dout[b]   = m_mem[b][rad];
                    m_dknown[b] = m_known[b][rad];
                end
                if (w) begin
                    m_mem[b][wad]   = din[b*DW +: DW];
                    m_known[b][wad] = 1'b1;
                end
                if (mem_clear[b]) m_busy_left[b] = RD;
            end
        end
    endtask

    initial begin
        int n;

        // Hand-derived vectors: bank fields packed {bank2, bank1, bank0}
        tbl[0] = '{cs:3'b110, we:3'b110, re:3'b000, wa:{4'd7,4'd3,4'd0}, ra:12'h000,
                   din:{8'h11,8'hA5,8'h00}, exp_rvld:3'b000, exp_dout:{8'h00,8'h00,8'h00}};
        tbl[1] = '{cs:3'b010, we:3'b000, re:3'b010, wa:12'h000, ra:{4'd0,4'd3,4'd0},
                   din:24'h0, exp_rvld:3'b010, exp_dout:{8'h00,8'hA5,8'h00}};
        tbl[2] = '{cs:3'b000, we:3'b000, re:3'b000, wa:12'h000, ra:12'h000,
                   din:24'h0, exp_rvld:3'b000, exp_dout:{8'h00,8'hA5,8'h00}};
        tbl[3] = '{cs:3'b100, we:3'b100, re:3'b100, wa:{4'd7,4'd0,4'd0}, ra:{4'd7,4'd0,4'd0},
                   din:{8'h22,8'h00,8'h00}, exp_rvld:3'b100, exp_dout:{8'h11,8'hA5,8'h00}};
        tbl[4] = '{cs:3'b100, we:3'b000, re:3'b100, wa:12'h000, ra:{4'd7,4'd0,4'd0},
                   din:24'h0, exp_rvld:3'b100, exp_dout:{8'h22,8'hA5,8'h00}};
        tbl[5] = '{cs:3'b000, we:3'b010, re:3'b010, wa:{4'd0,4'd3,4'd0}, ra:{4'd0,4'd3,4'd0},
                   din:{8'h00,8'hFF,8'h00}, exp_rvld:3'b000, exp_dout:{8'h22,8'hA5,8'h00}};
        tbl[6] = '{cs:3'b010, we:3'b000, re:3'b010, wa:12'h000, ra:{4'd0,4'd3,4'd0},
                   din:24'h0, exp_rvld:3'b010, exp_dout:{8'h22,8'hA5,8'h00}};
        tbl[7] = '{cs:3'b011, we:3'b000, re:3'b011, wa:12'h000, ra:{4'd0,4'd0,4'd5},
                   din:24'h0, exp_rvld:3'b011, exp_dout:{8'h22,8'h00,8'h00}};

        idle_inputs();
        rst_n = 1'b0;
        repeat (3) step();
        chk("reset_rvld", 32'(rvld), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_err",  32'(err),  32'h0);
        chk("reset_dout", 32'(dout), 32'h0);
        rst_n = 1'b1;
        step();

        // Clear all banks with a one-cycle pulse; bank 0 busy must last 16 cycles
        mem_clear = 3'b111;
        step();
        mem_clear = '0;
        chk("clr_busy_start", 32'(busy), 32'h7);
        n = 1;
        while (busy[0] && n < 40) begin
            step();
            if (busy[0]) n++;
        end
        chk("clr_busy_cycles", 32'(n), 32'd16);
        chk("clr_busy_end", 32'(busy), 32'h0);
        set_bank(0, 1, 0, 1, 4'd0, 4'd5, 8'h00);
        step();
        idle_inputs();
        chk("clr_read_vld", 32'(rvld), 32'h1);
        chk("clr_read_data", 32'(dout_b(0)), 32'h0);

        // Table: write/read latency, hold, read-first collision, CS gating
        for (int i = 0; i < 8; i++) begin
            cs = tbl[i].cs; we = tbl[i].we; re = tbl[i].re;
            wa = tbl[i].wa; ra = tbl[i].ra; din = tbl[i].din;
            step();
            chk($sformatf("tbl%0d_rvld", i), 32'(rvld), 32'(tbl[i].exp_rvld));
            chk($sformatf("tbl%0d_dout", i), 32'(dout), 32'(tbl[i].exp_dout));
            chk($sformatf("tbl%0d_err", i),  32'(err),  32'h0);
        end
        idle_inputs();

        // Access during clear on bank 0 while bank 1 reads normally
        mem_clear[0] = 1'b1;
        step();
        mem_clear = '0;
        repeat (3) step();
        set_bank(0, 1, 0, 1, 4'd0, 4'd2, 8'h00);
        set_bank(1, 1, 0, 1, 4'd0, 4'd3, 8'h00);
        step();
        idle_inputs();
        chk("dclr_rvld", 32'(rvld), 32'h2);
        chk("dclr_err", 32'(err), 32'h1);
        chk("dclr_bank1_data", 32'(dout_b(1)), 32'hA5);
        n = 0;
        while (busy[0] && n < 40) begin
            step();
            n++;
        end
        chk("dclr_done", 32'(busy), 32'h0);
        chk("dclr_err_sticky", 32'(err), 32'h1);

        // Bank 0 fills with index values; bank 1 sees the same writes without CS
        for (int a = 0; a < RD; a++) begin
            set_bank(0, 1, 1, 0, 4'(a), 4'd0, 8'(a));
            set_bank(1, 0, 1, 0, 4'(a), 4'd0, 8'(a));
            step();
        end
        idle_inputs();
        chk("gate_err1", 32'(err[1]), 32'h0);
        for (int a = 0; a < RD; a++) begin
            set_bank(0, 1, 0, 1, 4'd0, 4'(a), 8'h00);
            step();
            chk($sformatf("fill_rd%0d_vld", a), 32'(rvld[0]), 32'h1);
            chk($sformatf("fill_rd%0d", a), 32'(dout_b(0)), 32'(a));
        end
        idle_inputs();
        set_bank(1, 1, 0, 1, 4'd0, 4'd3, 8'h00);
        step();
        chk("gate_keep3", 32'(dout_b(1)), 32'hA5);
        set_bank(1, 1, 0, 1, 4'd0, 4'd5, 8'h00);
        step();
        idle_inputs();
        chk("gate_keep5", 32'(dout_b(1)), 32'h00);

        // Asynchronous reset in the middle of a bank 0 sweep
        mem_clear[0] = 1'b1;
        step();
        mem_clear = '0;
        repeat (6) step();
        set_bank(1, 1, 0, 1, 4'd0, 4'd3, 8'h00);
        step();
        idle_inputs();
        chk("pre_rst_busy", 32'(busy[0]), 32'h1);
        chk("pre_rst_rvld", 32'(rvld[1]), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'h0);
        chk("arst_rvld", 32'(rvld), 32'h0);
        chk("arst_err",  32'(err),  32'h0);
        chk("arst_dout", 32'(dout), 32'h0);
        #3 rst_n = 1'b1;
        step();
        chk("post_rst_idle", 32'(busy), 32'h0);
        set_bank(0, 1, 1, 0, 4'd9, 4'd0, 8'h5A);
        step();
        set_bank(0, 1, 0, 1, 4'd0, 4'd9, 8'h00);
        step();
        idle_inputs();
        chk("post_rst_vld", 32'(rvld), 32'h1);
        chk("post_rst_data", 32'(dout_b(0)), 32'h5A);
        chk("post_rst_err", 32'(err), 32'h0);

        // Randomized traffic against the behavioural model; contents start unknown
        for (int b = 0; b < NB; b++) begin
            m_busy_left[b] = 0;
            m_dknown[b] = 1'b0;
            m_err[b] = 1'b0;
            m_rvld[b] = 1'b0;
            for (int a = 0; a < RD; a++) m_known[b][a] = 1'b0;
        end
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int b = 0; b < NB; b++) begin
                mem_clear[b] = (cyc == 0) ? 1'b1 : ($urandom_range(0, 15) == 0);
                set_bank(b, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                         1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                         4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
            end
            model_cycle();
            step();
            for (int b = 0; b < NB; b++) begin
                chk($sformatf("rnd%0d_b%0d_rvld", cyc, b), 32'(rvld[b]), 32'(m_rvld[b]));
                chk($sformatf("rnd%0d_b%0d_busy", cyc, b), 32'(busy[b]), 32'(m_busy_left[b] > 0));
                chk($sformatf("rnd%0d_b%0d_err", cyc, b), 32'(err[b]), 32'(m_err[b]));
                if (m_dknown[b])
                    chk($sformatf("rnd%0d_b%0d_dout", cyc, b), 32'(dout_b(b)), 32'(m_dout[b]));
            end
        end
        idle_inputs();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
